mem_access_unit: RTL and testbench

Load/store unit between the CPU datapath's memory stage and the word-wide data memory port. It turns MIPS load/store requests (LW, LB, LBU, LH, LHU, LWL, LWR, SW, SB, SH) into word-aligned memory transactions. Sub-word stores are done as read-modify-write because the memory only writes whole words. Load results are extracted, sign- or zero-extended, or merged, then returned to the datapath under a valid/ready handshake.

---
 rtl/mau_pkg.sv | 54 +++++
 rtl/mau_if.sv | 44 ++++
 rtl/mau_lane_align.sv | 74 +++++++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mau_pkg.sv
// -----------------------------------------------------------------------------
// mau_pkg
// Shared types and helpers for the memory access unit.
//   mau_op_t        : 4-bit load/store opcode (codes 10..15 are illegal)
//   mau_state_t     : control FSM state encoding
//   mau_misaligned  : alignment check for an opcode at a byte offset
//   mau_is_load     : true for the opcodes that return memory data
// -----------------------------------------------------------------------------
package mau_pkg;

  typedef enum logic [3:0] {
    OP_LW  = 4'd0,
    OP_LB  = 4'd1,
    OP_LBU = 4'd2,
    OP_LH  = 4'd3,
    OP_LHU = 4'd4,
    OP_LWL = 4'd5,
    OP_LWR = 4'd6,
    OP_SW  = 4'd7,
    OP_SB  = 4'd8,
    OP_SH  = 4'd9
  } mau_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } mau_state_t;

  // Illegal opcodes report as misaligned so they never touch memory.
  function automatic logic mau_misaligned(input mau_op_t op, input logic [1:0] off);
    logic bad;
    case (op)
      OP_LW, OP_SW:          bad = (off != 2'b00);
      OP_LH, OP_LHU, OP_SH:  bad = off[0];
      OP_LB, OP_LBU, OP_SB,
      OP_LWL, OP_LWR:        bad = 1'b0;
      default:               bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic mau_is_load(input mau_op_t op);
    logic ld;
    case (op)
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LWL, OP_LWR: ld = 1'b1;
      default:                                             ld = 1'b0;
    endcase
    return ld;
  endfunction

endpackage : mau_pkg

// File: rtl/mau_if.sv
// -----------------------------------------------------------------------------
// mau_if
// Bundles the datapath request/response handshake and the data memory port.
//   Request  : req_valid, req_ready, req_op, req_addr, req_wdata, req_rt_old
//   Response : resp_valid, resp_rdata, resp_addr_error
//   Memory   : data_address, data_writedata, data_write, data_readdata
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready drops from that edge until the unit is
// idle again. resp_valid is a single-cycle pulse with no back-pressure, and
// resp_addr_error is meaningful only while resp_valid is high.
// Modports: slave = the load/store unit, master = datapath + memory side.
// -----------------------------------------------------------------------------
interface mau_if;
  import mau_pkg::*;

  logic        req_valid;
  logic        req_ready;
  mau_op_t     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rt_old;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_addr_error;

  logic [31:0] data_address;
  logic [31:0] data_writedata;
  logic        data_write;
  logic [31:0] data_readdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rt_old, data_readdata,
    output req_ready, resp_valid, resp_rdata, resp_addr_error,
    output data_address, data_writedata, data_write
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rt_old, data_readdata,
    input  req_ready, resp_valid, resp_rdata, resp_addr_error,
    input  data_address, data_writedata, data_write
  );

endinterface : mau_if

// File: rtl/mau_lane_align.sv
// -----------------------------------------------------------------------------
// mau_lane_align
// Purely combinational byte-lane steering for the load/store unit.
// Ports:
//   i_op      : opcode
//   i_off     : byte offset within the word (little-endian lanes)
//   i_mem     : word read from memory
//   i_wdata   : store data (rt)
//   i_rt_old  : current rt, merged into LWL/LWR results
//   o_load    : extracted / extended / merged load result
//   o_store   : word to write back (SW data, or SB/SH merged into i_mem)
// -----------------------------------------------------------------------------
module mau_lane_align
  import mau_pkg::*;
(
  input  mau_op_t     i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_mem,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rt_old,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);

  logic [4:0]  w_sh_k;     // 8*k
  logic [4:0]  w_sh_inv;   // 8*(3-k)
  logic [31:0] w_shr;      // memory word with byte k moved to lane 0
  logic [31:0] w_lane_mask;
  logic [31:0] w_lane_data;

  always_comb begin
    w_sh_k   = {i_off, 3'b000};
    w_sh_inv = {~i_off, 3'b000};
    w_shr    = i_mem >> w_sh_k;

    o_load = '0;
    case (i_op)
      OP_LW:  o_load = i_mem;
      OP_LB:  o_load = {{24{w_shr[7]}}, w_shr[7:0]};
      OP_LBU: o_load = {24'h0, w_shr[7:0]};
      OP_LH:  o_load = {{16{w_shr[15]}}, w_shr[15:0]};
      OP_LHU: o_load = {16'h0, w_shr[15:0]};
      // LWL fills the upper bytes from memory, keeps the low (3-k) bytes of rt.
      OP_LWL: o_load = (i_mem << w_sh_inv) | (i_rt_old & (32'h00FF_FFFF >> w_sh_k));
      // LWR fills the lower bytes from memory, keeps the high k bytes of rt.
      OP_LWR: o_load = w_shr | (i_rt_old & ~(32'hFFFF_FFFF >> w_sh_k));
      default: o_load = '0;
    endcase

    w_lane_mask = '0;
    w_lane_data = '0;
    case (i_op)
      OP_SB: begin
        w_lane_mask = 32'h0000_00FF << w_sh_k;
        w_lane_data = {4{i_wdata[7:0]}};
      end
      OP_SH: begin
        w_lane_mask = 32'h0000_FFFF << w_sh_k;
        w_lane_data = {2{i_wdata[15:0]}};
      end
      default: begin
        w_lane_mask = '0;
        w_lane_data = '0;
      end
    endcase

    if (i_op == OP_SW) begin
      o_store = i_wdata;
    end else begin
      o_store = (i_mem & ~w_lane_mask) | (w_lane_data & w_lane_mask);
    end
  end

endmodule : mau_lane_align

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Load/store unit between the memory stage and a word-wide data memory.
// Sub-word stores are read-modify-write since memory writes whole words.
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous, active-high; drops any transaction in flight
//   bus          : mau_if.slave (request, response and memory port)
//   o_dbg_state  : current FSM state, for observation only
// Flow per request:
//   misaligned/illegal : IDLE -> DONE
//   SW                 : IDLE -> WR -> DONE
//   loads              : IDLE -> RD -> WAIT -> DONE
//   SB/SH              : IDLE -> RD -> WAIT -> WR -> DONE
// -----------------------------------------------------------------------------
module mem_access_unit
  import mau_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       reset,
  mau_if.slave       bus,
  output mau_state_t o_dbg_state
);

  mau_state_t  r_state;
  mau_state_t  w_next_state;

  mau_op_t     r_op;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic [31:0] r_rt_old;
  logic [31:0] r_addr;
  logic [31:0] r_writedata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_req_misaligned;
  logic [31:0] w_load_data;
  logic [31:0] w_store_word;

  assign w_accept         = (r_state == ST_IDLE) && bus.req_valid;
  assign w_req_misaligned = mau_misaligned(bus.req_op, bus.req_addr[1:0]);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (w_req_misaligned) begin
            w_next_state = ST_DONE;
          end else if (bus.req_op == OP_SW) begin
            w_next_state = ST_WR;
          end else begin
            w_next_state = ST_RD;
          end
        end
      end
      ST_RD:   w_next_state = ST_WAIT;
      // Only loads and SB/SH pass through WAIT; the stores go on to write.
      ST_WAIT: w_next_state = mau_is_load(r_op) ? ST_DONE : ST_WR;
      ST_WR:   w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Lane steering
  // ---------------------------------------------------------------------------
  mau_lane_align u_lane_align (
    .i_op     (r_op),
    .i_off    (r_off),
    .i_mem    (bus.data_readdata),
    .i_wdata  (r_wdata),
    .i_rt_old (r_rt_old),
    .o_load   (w_load_data),
    .o_store  (w_store_word)
  );

  // ---------------------------------------------------------------------------
  // Request capture and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op        <= OP_LW;
      r_off       <= 2'b00;
      r_wdata     <= '0;
      r_rt_old    <= '0;
      r_addr      <= RESET_ADDR;
      r_writedata <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op     <= bus.req_op;
        r_off    <= bus.req_addr[1:0];
        r_wdata  <= bus.req_wdata;
        r_rt_old <= bus.req_rt_old;
        r_addr   <= {bus.req_addr[31:2], 2'b00};
        r_err    <= w_req_misaligned;
        if (w_req_misaligned) begin
          r_rdata <= '0;
        end else if (bus.req_op == OP_SW) begin
          r_writedata <= bus.req_wdata;
        end
      end
      if (r_state == ST_WAIT) begin
        if (mau_is_load(r_op)) begin
          r_rdata <= w_load_data;
        end else begin
          r_writedata <= w_store_word;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.req_ready       = (r_state == ST_IDLE);
  assign bus.resp_valid      = (r_state == ST_DONE);
  assign bus.resp_rdata      = r_rdata;
  assign bus.resp_addr_error = r_err;
  assign bus.data_address    = r_addr;
  assign bus.data_writedata  = r_writedata;
  // Gated by reset directly so a reset landing on WR never commits the write.
  assign bus.data_write      = (r_state == ST_WR) && !reset;
  assign o_dbg_state         = r_state;

endmodule : mem_access_unit

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench: a driver issues requests with hand-computed expectations
// pushed into queues; a monitor on the falling edge pops and compares each
// response and each memory write. A small registered memory model stands in
// for the data memory.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
  import mau_pkg::*;

  localparam logic [31:0] RST_ADDR = 32'h1000_0040;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_init;
  mau_state_t dbg_state;
  int         cyc = 0;

  int tests = 0;
  int fails = 0;

  // expected-response scoreboard
  logic [31:0] exp_rdata_q[$];
  logic [0:0]  exp_err_q[$];
  logic [31:0] exp_lat_q[$];
  int          issue_q[$];
  // expected memory writes
  logic [31:0] exp_waddr_q[$];
  logic [31:0] exp_wdata_q[$];

  mau_if bus ();

  mem_access_unit #(.RESET_ADDR(RST_ADDR)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  logic [31:0] mem [0:15];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h8899_AABB;
    end else if (bus.data_write) begin
      mem[bus.data_address[5:2]] <= bus.data_writedata;
    end
    bus.data_readdata <= mem[bus.data_address[5:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int b = 0;
    while (!bus.req_ready && b < 50) begin
      @(posedge clk); #1;
      b++;
    end
    check("req_ready_timeout", {31'h0, bus.req_ready}, 32'h1);
  endtask

  task automatic issue(input mau_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rt, input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_lat, input logic exp_wr, input logic [31:0] exp_wdata);
    wait_ready();
    exp_rdata_q.push_back(exp_rdata);
    exp_err_q.push_back(exp_err);
    exp_lat_q.push_back(32'(exp_lat));
    issue_q.push_back(cyc);
    if (exp_wr) begin
      exp_waddr_q.push_back({addr[31:2], 2'b00});
      exp_wdata_q.push_back(exp_wdata);
    end
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_rt_old = rt;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  {31'h0, bus.req_ready}, 32'h1);
    check({tag, "_resp_valid"}, {31'h0, bus.resp_valid}, 32'h0);
    check({tag, "_resp_rdata"}, bus.resp_rdata, 32'h0);
    check({tag, "_addr_error"}, {31'h0, bus.resp_addr_error}, 32'h0);
    check({tag, "_data_addr"},  bus.data_address, RST_ADDR);
    check({tag, "_data_wdata"}, bus.data_writedata, 32'h0);
    check({tag, "_data_write"}, {31'h0, bus.data_write}, 32'h0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [31:0] e_rdata;
    logic [0:0]  e_err;
    logic [31:0] e_lat;
    int          t_issue;
    if (bus.resp_valid) begin
      if (exp_rdata_q.size() == 0) begin
        check("resp_without_request", 32'(exp_rdata_q.size()), 32'h1);
      end else begin
        e_rdata = exp_rdata_q.pop_front();
        e_err   = exp_err_q.pop_front();
        e_lat   = exp_lat_q.pop_front();
        t_issue = issue_q.pop_front();
        check("resp_rdata", bus.resp_rdata, e_rdata);
        check("resp_addr_error", {31'h0, bus.resp_addr_error}, {31'h0, e_err});
        check("resp_latency", 32'(cyc - t_issue), e_lat);
        check("ready_low_in_done", {31'h0, bus.req_ready}, 32'h0);
      end
    end
    if (bus.data_write) begin
      if (exp_waddr_q.size() == 0) begin
        check("write_without_store", 32'(exp_waddr_q.size()), 32'h1);
      end else begin
        check("write_addr", bus.data_address, exp_waddr_q.pop_front());
        check("write_data", bus.data_writedata, exp_wdata_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset          = 1'b1;
    mem_init       = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = OP_LW;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_rt_old = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset    = 1'b0;
    mem_init = 1'b0;

    //    op      addr           wdata          rt_old         rdata          err lat wr wdata
    issue(OP_LB,  32'h1000_0001, 32'h0,         32'h0,         32'hFFFF_FFAA, 0, 3, 0, 32'h0);
    issue(OP_LBU, 32'h1000_0001, 32'h0,         32'h0,         32'h0000_00AA, 0, 3, 0, 32'h0);
    issue(OP_LH,  32'h1000_0002, 32'h0,         32'h0,         32'hFFFF_8899, 0, 3, 0, 32'h0);
    issue(OP_LHU, 32'h1000_0002, 32'h0,         32'h0,         32'h0000_8899, 0, 3, 0, 32'h0);
    issue(OP_LW,  32'h1000_0000, 32'h0,         32'h0,         32'h8899_AABB, 0, 3, 0, 32'h0);
    issue(OP_LWL, 32'h1000_0001, 32'h0,         32'h1122_3344, 32'hAABB_3344, 0, 3, 0, 32'h0);
    issue(OP_LWR, 32'h1000_0001, 32'h0,         32'h1122_3344, 32'h1188_99AA, 0, 3, 0, 32'h0);
    // stores leave resp_rdata at the last load result
    issue(OP_SB,  32'h1000_0002, 32'h0000_0012, 32'h0,         32'h1188_99AA, 0, 4, 1, 32'h8812_AABB);
    issue(OP_LW,  32'h1000_0000, 32'h0,         32'h0,         32'h8812_AABB, 0, 3, 0, 32'h0);
    // misaligned: no memory access, rdata forced to 0
    issue(OP_LW,  32'h1000_0002, 32'h0,         32'h0,         32'h0,         1, 1, 0, 32'h0);
    issue(OP_SH,  32'h1000_0001, 32'h0000_FFFF, 32'h0,         32'h0,         1, 1, 0, 32'h0);
    issue(OP_SW,  32'h1000_0004, 32'hDEAD_BEEF, 32'h0,         32'h0,         0, 2, 1, 32'hDEAD_BEEF);
    issue(OP_SH,  32'h1000_0006, 32'h0000_5678, 32'h0,         32'h0,         0, 4, 1, 32'h5678_BEEF);
    issue(OP_LH,  32'h1000_0006, 32'h0,         32'h0,         32'h0000_5678, 0, 3, 0, 32'h0);
    issue(OP_LB,  32'h1000_0003, 32'h0,         32'h0,         32'hFFFF_FF88, 0, 3, 0, 32'h0);
    issue(OP_LWL, 32'h1000_0000, 32'h0,         32'h1122_3344, 32'hBB22_3344, 0, 3, 0, 32'h0);
    issue(OP_LWR, 32'h1000_0003, 32'h0,         32'h1122_3344, 32'h1122_3388, 0, 3, 0, 32'h0);
    issue(OP_LWL, 32'h1000_0003, 32'h0,         32'h1122_3344, 32'h8812_AABB, 0, 3, 0, 32'h0);
    issue(OP_LWR, 32'h1000_0000, 32'h0,         32'h1122_3344, 32'h8812_AABB, 0, 3, 0, 32'h0);
    issue(mau_op_t'(4'd10), 32'h1000_0000, 32'h0, 32'h0,       32'h0,         1, 1, 0, 32'h0);
    issue(OP_SB,  32'h1000_0007, 32'h0000_00AB, 32'h0,         32'h0,         0, 4, 1, 32'hAB78_BEEF);
    issue(OP_LBU, 32'h1000_0007, 32'h0,         32'h0,         32'h0000_00AB, 0, 3, 0, 32'h0);

    // SH dropped by a reset landing on its WR cycle: no write, no response
    wait_ready();
    bus.req_valid  = 1'b1;
    bus.req_op     = OP_SH;
    bus.req_addr   = 32'h1000_0000;
    bus.req_wdata  = 32'h0000_FFFF;
    bus.req_rt_old = 32'h0;
    @(posedge clk); #1;          // RD
    bus.req_valid  = 1'b0;
    @(posedge clk); #1;          // WAIT
    @(posedge clk); #1;          // WR
    reset = 1'b1;
    #1;
    check("write_masked_by_reset", {31'h0, bus.data_write}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_outputs("mid_op_reset");

    // memory must still hold the pre-SH word
    issue(OP_LW,  32'h1000_0000, 32'h0,         32'h0,         32'h8812_AABB, 0, 3, 0, 32'h0);

    begin
      int b = 0;
      while (exp_rdata_q.size() != 0 && b < 100) begin
        @(posedge clk);
        b++;
      end
    end
    @(negedge clk); #1;
    check("pending_responses", 32'(exp_rdata_q.size()), 32'h0);
    check("pending_writes", 32'(exp_waddr_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // hard stop in case something wedges
  initial begin
    #200000;
    $display("FAIL global_timeout: actual cycle %0d required finish", cyc);
    $fatal(1, "timeout");
  end

endmodule : tb_mem_access_unit
